des_key_schedule: RTL and testbench

Sequential DES key-schedule engine that sits directly upstream of the round function. It loads a 64-bit key, applies PC-1, and then emits the 16 48-bit subkeys one per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). Each subkey is produced by rotating the 28-bit C/D halves and applying PC-2. The round engine consumes `subkey` and pulls the next one by asserting `subkey_ready`.

---
 rtl/des_pkg.sv | 78 +++++++
 rtl/des_pc2.sv | 17 +
 rtl/des_key_schedule.sv | 124 ++++++++++++
 tb/tb_des_key_schedule.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule shared definitions: widths, PC-1/PC-2/SHIFT tables,
// FSM state enum, PC-1 and 28-bit rotate helpers.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ROTL1 = 2'd0,
    ROTL2 = 2'd1,
    ROTR1 = 2'd2,
    ROTR2 = 2'd3
  } rot_t;

  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2,
    1, 2, 2, 2, 2, 2, 2, 1
  };

  // Table entries are DES bit numbers: bit 1 is the MSB.
  function automatic logic [CD_W-1:0] pc1_f(
    input logic [KEY_W-1:0] k
  );
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++) begin
      r[CD_W-1-i] = k[KEY_W-PC1[i]];
    end
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rot28_f(
    input logic [HALF_W-1:0] x,
    input rot_t              sel
  );
    logic [HALF_W-1:0] r;
    r = x;
    unique case (sel)
      ROTL1: r = {x[26:0], x[27]};
      ROTL2: r = {x[25:0], x[27:26]};
      ROTR1: r = {x[0], x[27:1]};
      ROTR2: r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2: combinational 56-bit {C,D} to 48-bit subkey permutation.
// Ports: cd (56, C in the upper half), subkey (48).
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[SUBKEY_W-1-i] = cd[CD_W-PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: loads a key, emits K1..K16 (or K16..K1) over a
// valid/ready handshake. Ports: clk, rst, start, key, decrypt in;
// subkey, subkey_valid, subkey_ready(in), round_idx, busy, done.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_W-1:0]    key,
  input  logic                decrypt,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done
);

  state_t state_q;
  state_t state_d;

  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic [3:0]        round_q;
  logic              dir_q;

  logic              load;
  logic              hs;
  logic              last;
  logic [3:0]        sh_idx;
  logic              two;
  rot_t              rot_sel;
  logic [CD_W-1:0]   pc1_v;
  logic [HALF_W-1:0] c_ld;
  logic [HALF_W-1:0] d_ld;
  logic [HALF_W-1:0] c_nx;
  logic [HALF_W-1:0] d_nx;

  assign load = (state_q == IDLE) && start;
  assign hs   = (state_q == GEN) && subkey_ready;
  assign last = (round_q == 4'd15);

  // Encrypt steps forward through SHIFT; decrypt walks it backwards
  // and undoes each rotation.
  always_comb begin
    sh_idx = dir_q ? (4'd15 - round_q)
                   : (round_q + 4'd1);
    two    = (SHIFT[sh_idx] == 2);
    rot_sel = ROTL1;
    unique case (1'b1)
      (!dir_q && !two): rot_sel = ROTL1;
      (!dir_q &&  two): rot_sel = ROTL2;
      ( dir_q && !two): rot_sel = ROTR1;
      ( dir_q &&  two): rot_sel = ROTR2;
      default:          rot_sel = ROTL1;
    endcase
  end

  assign c_nx = rot28_f(c_q, rot_sel);
  assign d_nx = rot28_f(d_q, rot_sel);

  // Decrypt loads unrotated: a full schedule rotates by 28, so the
  // PC-1 output already equals the K16 halves.
  always_comb begin
    pc1_v = pc1_f(key);
    c_ld  = pc1_v[CD_W-1:HALF_W];
    d_ld  = pc1_v[HALF_W-1:0];
    if (!decrypt) begin
      c_ld = rot28_f(pc1_v[CD_W-1:HALF_W], ROTL1);
      d_ld = rot28_f(pc1_v[HALF_W-1:0], ROTL1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = GEN;
      GEN:     if (hs && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    subkey_valid = (state_q == GEN);
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else if (load) begin
      c_q     <= c_ld;
      d_q     <= d_ld;
      round_q <= '0;
      dir_q   <= decrypt;
    end else if (hs && !last) begin
      c_q     <= c_nx;
      d_q     <= d_nx;
      round_q <= round_q + 4'd1;
    end
  end

  assign round_idx = round_q;

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a table-driven
// DES key-schedule model using cumulative rotation amounts.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  logic [47:0] cap     [16];
  logic [47:0] enc_cap [16];
  logic [47:0] exp_k   [16];

  localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  int m_pc1 [56] = '{
    57,49,41,33,25,17,9,1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,19,11,3,60,52,44,36,
    63,55,47,39,31,23,15,7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,21,13,5,28,20,12,4
  };
  int m_pc2 [48] = '{
    14,17,11,24,1,5,3,28,15,6,21,10,
    23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32
  };
  int m_sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key          (key),
    .decrypt      (decrypt),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subkey Ki (i = 1..16): halves rotated left by the sum of the
  // first i shift amounts, then PC-2.
  function automatic logic [47:0] model_k(
    input logic [63:0] k,
    input int          i
  );
    logic [55:0] cd;
    logic [55:0] t;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] o;
    int rot;
    for (int j = 0; j < 56; j++) cd[55-j] = k[64-m_pc1[j]];
    rot = 0;
    for (int j = 0; j < i; j++) rot += m_sh[j];
    t = {cd[55:28], cd[55:28]} << rot;
    c = t[55:28];
    t = {cd[27:0], cd[27:0]} << rot;
    d = t[55:28];
    cd = {c, d};
    for (int j = 0; j < 48; j++) o[47-j] = cd[56-m_pc2[j]];
    return o;
  endfunction

  task automatic run_seq(
    input logic [63:0] k,
    input logic        dec,
    input int          pct,
    input int          inj
  );
    int n;
    int cyc;
    bit injected;
    bit r;
    logic [47:0] held;
    for (int i = 0; i < 16; i++)
      exp_k[i] = model_k(k, dec ? 16 - i : i + 1);
    key = k;
    decrypt = dec;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = {$urandom, $urandom};
    decrypt = 1'($urandom);
    n_checks++;
    if (subkey_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: valid=%b want 1", subkey_valid);
    end
    n = 0;
    cyc = 0;
    injected = 0;
    while (n < 16 && cyc < 400) begin
      n_checks++;
      if (subkey !== exp_k[n] || round_idx !== 4'(n)) begin
        n_fail++;
        $display("FAIL subkey[%0d]: got %h idx %0d want %h",
                 n, subkey, round_idx, exp_k[n]);
      end
      if (inj >= 0 && n == inj && !injected) begin
        start = 1'b1;
        key = ~k;
        decrypt = ~dec;
        injected = 1;
      end
      r = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      subkey_ready = r;
      held = subkey;
      @(posedge clk); #1;
      start = 1'b0;
      if (r) begin
        cap[n] = held;
        n++;
      end
      cyc++;
    end
    subkey_ready = 1'($urandom);
    n_checks++;
    if (n < 16) begin
      n_fail++;
      $display("FAIL timeout: accepted %0d want 16", n);
    end
    n_checks++;
    if (done !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_cycle: done=%b valid=%b busy=%b want 1 0 1",
               done, subkey_valid, busy);
    end
    if (pct >= 100) begin
      n_checks++;
      if (cyc != 16) begin
        n_fail++;
        $display("FAIL throughput: cycles=%0d want 16", cyc);
      end
    end
    if (inj >= 0) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (subkey !== 48'h0 || subkey_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: sk=%h v=%b b=%b d=%b idx=%0d want zeros",
               subkey, subkey_valid, busy, done, round_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt();
    run_seq(KEY0, 1'b0, 100, -1);
    for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];
    n_checks++;
    if (enc_cap[0] !== K1 || enc_cap[15] !== K16) begin
      n_fail++;
      $display("FAIL enc_vector: k1=%h k16=%h want %h %h",
               enc_cap[0], enc_cap[15], K1, K16);
    end
  endtask

  task automatic test_decrypt();
    run_seq(KEY0, 1'b1, 100, -1);
    n_checks++;
    if (cap[0] !== K16 || cap[15] !== K1) begin
      n_fail++;
      $display("FAIL dec_vector: r0=%h r15=%h want %h %h",
               cap[0], cap[15], K16, K1);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (cap[i] !== enc_cap[15-i]) begin
        n_fail++;
        $display("FAIL dec_reverse[%0d]: got %h want %h",
                 i, cap[i], enc_cap[15-i]);
      end
    end
  endtask

  task automatic test_backpressure();
    run_seq(KEY0, 1'b0, 30, -1);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (cap[i] !== enc_cap[i]) begin
        n_fail++;
        $display("FAIL bp_seq[%0d]: got %h want %h",
                 i, cap[i], enc_cap[i]);
      end
    end
    for (int t = 0; t < 4; t++)
      run_seq({$urandom, $urandom}, 1'($urandom), 30, -1);
  endtask

  task automatic test_start_ignored();
    run_seq(KEY0, 1'b0, 100, 7);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (cap[i] !== enc_cap[i]) begin
        n_fail++;
        $display("FAIL start_ign[%0d]: got %h want %h",
                 i, cap[i], enc_cap[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    key = {$urandom, $urandom};
    decrypt = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    subkey_ready = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        subkey !== 48'h0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst: v=%b b=%b d=%b sk=%h idx=%0d want zeros",
               subkey_valid, busy, done, subkey, round_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst[%0d]: busy=%b done=%b want 0 0",
                 i, busy, done);
      end
    end
    run_seq(KEY0, 1'b0, 100, -1);
    n_checks++;
    if (cap[0] !== K1) begin
      n_fail++;
      $display("FAIL rst_restart: k1=%h want %h", cap[0], K1);
    end
  endtask

  task automatic test_back_to_back();
    run_seq({$urandom, $urandom}, 1'b1, 100, -1);
    run_seq({$urandom, $urandom}, 1'b0, 100, -1);
    run_seq({$urandom, $urandom}, 1'($urandom), 50, -1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    start = 1'b0;
    key = '0;
    decrypt = 1'b0;
    subkey_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
